mmio_gpio: RTL and testbench

Memory-mapped GPIO peripheral sitting directly downstream of the CPU MEM stage on the data bus. It decodes a 16-byte address window and drives the board LEDs, synchronises and debounces the push buttons, and latches button press events. Every decoded access completes with a one-cycle `mem_memready` handshake. Accesses outside the window are ignored and left for data memory.

---
 rtl/mmio_gpio_if.sv | 28 ++
 rtl/mmio_gpio.sv | 143 ++++++++++++++
 tb/tb_mmio_gpio.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_gpio_if.sv
// Data-bus port between the CPU MEM stage and the GPIO block.
// The master issues requests; the slave returns a one-cycle ready.
interface mmio_gpio_if;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [31:0] mem_memaddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_memready;

  modport master (
    output mem_memread,
    output mem_memwrite,
    output mem_memaddr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_memready
  );

  modport slave (
    input  mem_memread,
    input  mem_memwrite,
    input  mem_memaddr,
    input  mem_wdata,
    output mem_rdata,
    output mem_memready
  );
endinterface

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: LED register, debounced buttons and
// sticky press-event flags behind a 16-byte window.
module mmio_gpio #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic             g_clk,
  input  logic             g_rst_n,
  mmio_gpio_if.slave       bus,
  output logic [8:0]       g_leds,
  input  logic [7:0]       g_buttons
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t state;
  state_t nxt;

  logic [8:0]    leds;
  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [7:0]    stable;
  logic [7:0]    pend;
  logic [7:0]    rise;
  logic [7:0]    clr;
  logic [CW-1:0] cnt [8];
  logic [31:0]   rdata_q;
  logic [31:0]   rd_mux;

  logic hit;
  logic take;
  logic wr_take;
  logic sel_leds;
  logic sel_btn;
  logic sel_pend;
  logic sel_tog;
  logic unused;

  assign unused = ^{bus.mem_memaddr[1:0],
                    bus.mem_wdata[31:9]};

  assign hit = (bus.mem_memread | bus.mem_memwrite)
             & (bus.mem_memaddr[31:4] == BASE_ADDR[31:4]);
  assign take    = hit & (state == IDLE);
  assign wr_take = take & bus.mem_memwrite;

  assign sel_leds = bus.mem_memaddr[3:2] == 2'd0;
  assign sel_btn  = bus.mem_memaddr[3:2] == 2'd1;
  assign sel_pend = bus.mem_memaddr[3:2] == 2'd2;
  assign sel_tog  = bus.mem_memaddr[3:2] == 2'd3;

  always_comb begin
    rd_mux = 32'd0;
    unique case (1'b1)
      sel_leds: rd_mux = {23'd0, leds};
      sel_btn:  rd_mux = {24'd0, stable};
      sel_pend: rd_mux = {24'd0, pend};
      sel_tog:  rd_mux = 32'd0;
      default:  rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE:    nxt = hit ? ACK : IDLE;
      ACK:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_memready = (state == ACK);
    bus.mem_rdata    = (state == ACK) ? rdata_q : 32'd0;
  end

  // Read data is frozen at the sampling edge; writes read back 0.
  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      rdata_q <= 32'd0;
    end else if (take) begin
      rdata_q <= bus.mem_memwrite ? 32'd0 : rd_mux;
    end
  end

  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      leds <= 9'd0;
    end else if (wr_take & sel_leds) begin
      leds <= bus.mem_wdata[8:0];
    end else if (wr_take & sel_tog) begin
      leds <= leds ^ bus.mem_wdata[8:0];
    end
  end

  assign g_leds = leds;

  assign clr = (wr_take & sel_pend) ? bus.mem_wdata[7:0] : 8'd0;

  always_comb begin
    rise = 8'd0;
    for (int i = 0; i < 8; i++) begin
      rise[i] = sync2[i] & ~stable[i] & (cnt[i] == CMAX);
    end
  end

  // A fresh edge wins over a same-cycle clear.
  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) pend <= 8'd0;
    else          pend <= (pend & ~clr) | rise;
  end

  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      sync1  <= 8'd0;
      sync2  <= 8'd0;
      stable <= 8'd0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      sync1 <= g_buttons;
      sync2 <= sync1;
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio with a queue-based
// scoreboard checking every ready cycle.
module tb_mmio_gpio;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic       clk;
  logic       rst_n;
  logic [8:0] leds;
  logic [7:0] btn;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] sb [$];
  logic        prev_rdy = 1'b0;

  mmio_gpio_if bus ();

  mmio_gpio #(
    .BASE_ADDR       (BASE),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .g_clk     (clk),
    .g_rst_n   (rst_n),
    .bus       (bus.slave),
    .g_leds    (leds),
    .g_buttons (btn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_memready === 1'b1) begin
      chk("single_cycle_ready", {31'd0, prev_rdy}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        chk("rdata", bus.mem_rdata, sb.pop_front());
      end
    end else begin
      chk("idle_rdata", bus.mem_rdata, 32'd0);
    end
    prev_rdy = (bus.mem_memready === 1'b1);
  end

  task automatic access(input logic rd,
                        input logic wr,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic exp_ack,
                        input logic [31:0] exp_rd,
                        output logic [8:0] leds_n);
    @(negedge clk);
    bus.mem_memread  = rd;
    bus.mem_memwrite = wr;
    bus.mem_memaddr  = addr;
    bus.mem_wdata    = wd;
    if (exp_ack) sb.push_back(exp_rd);
    @(posedge clk);
    #1;
    leds_n = leds;
    bus.mem_memread  = 1'b0;
    bus.mem_memwrite = 1'b0;
    bus.mem_memaddr  = 32'd0;
    bus.mem_wdata    = 32'd0;
    @(posedge clk);
  endtask

  task automatic rd_chk(input logic [31:0] addr,
                        input logic [31:0] exp);
    logic [8:0] l;
    access(1'b1, 1'b0, addr, 32'd0, 1'b1, exp, l);
  endtask

  task automatic wr_do(input logic [31:0] addr,
                       input logic [31:0] wd,
                       output logic [8:0] l);
    access(1'b0, 1'b1, addr, wd, 1'b1, 32'd0, l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] l;
    rst_n            = 1'b0;
    btn              = 8'd0;
    bus.mem_memread  = 1'b0;
    bus.mem_memwrite = 1'b0;
    bus.mem_memaddr  = 32'd0;
    bus.mem_wdata    = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_leds", {23'd0, leds}, 32'd0);
      chk("reset_ready", {31'd0, bus.mem_memready}, 32'd0);
    end

    wr_do(BASE, 32'h1A5, l);
    chk("leds_write", {23'd0, l}, 32'h1A5);
    rd_chk(BASE, 32'h0000_01A5);
    wr_do(BASE + 32'hC, 32'h0FF, l);
    chk("leds_toggle", {23'd0, l}, 32'h15A);
    rd_chk(BASE + 32'hC, 32'd0);
    rd_chk(BASE + 32'h3, 32'h15A);
    wr_do(BASE + 32'h4, 32'hFF, l);
    rd_chk(BASE + 32'h4, 32'd0);

    access(1'b1, 1'b0, BASE + 32'h10, 32'd0, 1'b0, 32'd0, l);
    access(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, l);
    access(1'b0, 1'b1, BASE + 32'h10, 32'h0, 1'b0, 32'd0, l);
    chk("miss_write_leds", {23'd0, leds}, 32'h15A);

    @(negedge clk);
    btn = 8'h01;
    repeat (17) @(posedge clk);
    rd_chk(BASE + 32'h4, 32'h00);
    rd_chk(BASE + 32'h4, 32'h01);
    rd_chk(BASE + 32'h8, 32'h01);
    wr_do(BASE + 32'h8, 32'h01, l);
    rd_chk(BASE + 32'h8, 32'h00);

    @(negedge clk);
    btn = 8'h00;
    repeat (18) @(posedge clk);
    rd_chk(BASE + 32'h4, 32'h00);
    rd_chk(BASE + 32'h8, 32'h00);

    @(negedge clk);
    btn = 8'h02;
    repeat (10) @(negedge clk);
    btn = 8'h00;
    repeat (30) @(posedge clk);
    rd_chk(BASE + 32'h4, 32'h00);
    rd_chk(BASE + 32'h8, 32'h00);

    @(negedge clk);
    btn = 8'h02;
    repeat (17) @(posedge clk);
    wr_do(BASE + 32'h8, 32'h02, l);
    rd_chk(BASE + 32'h8, 32'h02);
    rd_chk(BASE + 32'h4, 32'h02);

    access(1'b1, 1'b1, BASE, 32'h003, 1'b1, 32'd0, l);
    chk("rw_leds", {23'd0, l}, 32'h003);
    rd_chk(BASE, 32'h003);

    @(negedge clk);
    bus.mem_memwrite = 1'b1;
    bus.mem_memaddr  = BASE;
    bus.mem_wdata    = 32'h055;
    @(posedge clk);
    #1;
    bus.mem_memwrite = 1'b0;
    bus.mem_memaddr  = 32'd0;
    bus.mem_wdata    = 32'd0;
    chk("pre_rst_leds", {23'd0, leds}, 32'h055);
    chk("pre_rst_ready", {31'd0, bus.mem_memready}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_ack_ready", {31'd0, bus.mem_memready}, 32'd0);
    chk("rst_ack_leds", {23'd0, leds}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    rd_chk(BASE, 32'd0);
    rd_chk(BASE + 32'h8, 32'd0);

    repeat (4) @(posedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nchk, nerr);
    $finish;
  end

endmodule
